// File: rtl/stack_engine.sv
// Stack/memory command engine: PUSH, POP, RD, WR, INT against an external data memory.
// Optional macro STACK_GUARD_EN faults stack overflow/underflow instead of wrapping sp.
module stack_engine #(
  parameter logic [7:0] SP_INIT  = 8'hFF,
  parameter logic [7:0] VEC_ADDR = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] sp,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH     = 3'd1;
  localparam logic [2:0] S_POP      = 3'd2;
  localparam logic [2:0] S_RD       = 3'd3;
  localparam logic [2:0] S_WR       = 3'd4;
  localparam logic [2:0] S_INT_PUSH = 3'd5;
  localparam logic [2:0] S_INT_VEC  = 3'd6;
  localparam logic [2:0] S_RSP      = 3'd7;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_RD   = 3'b011;
  localparam logic [2:0] OP_WR   = 3'b100;
  localparam logic [2:0] OP_INT  = 3'b101;

  logic [2:0] state;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       fault;
  logic       guard_hit;
  logic [7:0] sp_inc;
  logic [7:0] sp_dec;

  assign sp_inc = sp + 8'd1;
  assign sp_dec = sp - 8'd1;

`ifdef STACK_GUARD_EN
  // sp cannot move between acceptance and the stack access, so check it up front
  assign guard_hit = (((cmd_op == OP_PUSH) || (cmd_op == OP_INT)) && (sp == 8'h00)) ||
                     ((cmd_op == OP_POP) && (sp == 8'hFF));
`else
  assign guard_hit = 1'b0;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sp       <= SP_INIT;
      rsp_data <= 8'h00;
      rsp_err  <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            fault  <= guard_hit;
            case (cmd_op)
              OP_PUSH: state <= S_PUSH;
              OP_POP:  state <= S_POP;
              OP_RD:   state <= S_RD;
              OP_WR:   state <= S_WR;
              OP_INT:  state <= S_INT_PUSH;
              default: begin
                state    <= S_RSP;
                rsp_data <= 8'h00;
                rsp_err  <= 1'b0;
              end
            endcase
          end
        end
        S_PUSH: begin
          if (!fault) sp <= sp_dec;
          rsp_data <= 8'h00;
          rsp_err  <= fault;
          state    <= S_RSP;
        end
        S_POP: begin
          if (!fault) sp <= sp_inc;
          rsp_data <= fault ? 8'h00 : mem_rdata;
          rsp_err  <= fault;
          state    <= S_RSP;
        end
        S_RD: begin
          rsp_data <= mem_rdata;
          rsp_err  <= 1'b0;
          state    <= S_RSP;
        end
        S_WR: begin
          rsp_data <= 8'h00;
          rsp_err  <= 1'b0;
          state    <= S_RSP;
        end
        S_INT_PUSH: begin
          // a faulted INT skips the vector fetch and responds one cycle early
          if (fault) begin
            rsp_data <= 8'h00;
            rsp_err  <= 1'b1;
            state    <= S_RSP;
          end else begin
            sp    <= sp_dec;
            state <= S_INT_VEC;
          end
        end
        S_INT_VEC: begin
          rsp_data <= mem_rdata;
          rsp_err  <= 1'b0;
          state    <= S_RSP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    case (state)
      S_PUSH, S_INT_PUSH: begin
        if (!fault) begin
          mem_write = 1'b1;
          mem_addr  = sp;
          mem_wdata = data_q;
        end
      end
      S_POP: begin
        if (!fault) begin
          mem_read = 1'b1;
          mem_addr = sp_inc;
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
      end
      S_INT_VEC: begin
        mem_read = 1'b1;
        mem_addr = VEC_ADDR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with a small behavioural data memory.
module tb_stack_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] sp;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  stack_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .sp(sp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one acceptance edge, then scramble inputs to prove latching.
  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'b001;
    cmd_addr  = 8'h33;
    cmd_data  = 8'h99;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 8'h00; cmd_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    chk("rst_sp", sp, 8'hFF);
    chk("rst_mem_read", {7'd0, mem_read}, 8'd0);
    chk("rst_mem_write", {7'd0, mem_write}, 8'd0);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);

    // PUSH 0x42
    issue(3'b001, 8'h00, 8'h42);
    chk("push_wr", {7'd0, mem_write}, 8'd1);
    chk("push_rd", {7'd0, mem_read}, 8'd0);
    chk("push_addr", mem_addr, 8'hFF);
    chk("push_wdata", mem_wdata, 8'h42);
    chk("push_ready", {7'd0, cmd_ready}, 8'd0);
    chk("push_rv_t1", {7'd0, rsp_valid}, 8'd0);
    tick();
    chk("push_rv", {7'd0, rsp_valid}, 8'd1);
    chk("push_sp", sp, 8'hFE);
    chk("push_rdata", rsp_data, 8'h00);
    chk("push_rsp_wr", {7'd0, mem_write}, 8'd0);
    tick();
    chk("push_rv_drop", {7'd0, rsp_valid}, 8'd0);
    chk("push_idle_ready", {7'd0, cmd_ready}, 8'd1);

    // POP -> 0x42
    issue(3'b010, 8'h00, 8'h00);
    chk("pop_rd", {7'd0, mem_read}, 8'd1);
    chk("pop_wr", {7'd0, mem_write}, 8'd0);
    chk("pop_addr", mem_addr, 8'hFF);
    tick();
    chk("pop_rv", {7'd0, rsp_valid}, 8'd1);
    chk("pop_data", rsp_data, 8'h42);
    chk("pop_sp", sp, 8'hFF);
    chk("pop_err", {7'd0, rsp_err}, 8'd0);
    tick();
    chk("pop_hold", rsp_data, 8'h42);

    // WR 0x10 <- 0xAA, then RD 0x10
    issue(3'b100, 8'h10, 8'hAA);
    chk("wr_wr", {7'd0, mem_write}, 8'd1);
    chk("wr_addr", mem_addr, 8'h10);
    chk("wr_wdata", mem_wdata, 8'hAA);
    tick();
    chk("wr_rv", {7'd0, rsp_valid}, 8'd1);
    chk("wr_sp", sp, 8'hFF);
    tick();
    issue(3'b011, 8'h10, 8'h00);
    chk("rd_rd", {7'd0, mem_read}, 8'd1);
    chk("rd_addr", mem_addr, 8'h10);
    tick();
    chk("rd_rv", {7'd0, rsp_valid}, 8'd1);
    chk("rd_data", rsp_data, 8'hAA);
    chk("rd_sp", sp, 8'hFF);
    tick();

    // vector preload M[0x01]=0x80, then INT with return PC 0x37
    issue(3'b100, 8'h01, 8'h80);
    tick(); tick();
    issue(3'b101, 8'h00, 8'h37);
    chk("int_wr", {7'd0, mem_write}, 8'd1);
    chk("int_waddr", mem_addr, 8'hFF);
    chk("int_wdata", mem_wdata, 8'h37);
    tick();
    chk("int_vec_rd", {7'd0, mem_read}, 8'd1);
    chk("int_vec_wr", {7'd0, mem_write}, 8'd0);
    chk("int_vec_addr", mem_addr, 8'h01);
    chk("int_rv_t2", {7'd0, rsp_valid}, 8'd0);
    tick();
    chk("int_rv", {7'd0, rsp_valid}, 8'd1);
    chk("int_data", rsp_data, 8'h80);
    chk("int_sp", sp, 8'hFE);
    chk("int_mem_ff", mem[8'hFF], 8'h37);
    tick();
    issue(3'b010, 8'h00, 8'h00);
    tick();
    chk("int_pop_data", rsp_data, 8'h37);
    chk("int_pop_sp", sp, 8'hFF);
    tick();

    // NOP and an undefined opcode
    issue(3'b000, 8'h00, 8'h00);
    chk("nop_rv", {7'd0, rsp_valid}, 8'd1);
    chk("nop_data", rsp_data, 8'h00);
    chk("nop_mem", {6'd0, mem_read, mem_write}, 8'd0);
    tick();
    issue(3'b111, 8'h00, 8'h00);
    chk("op7_rv", {7'd0, rsp_valid}, 8'd1);
    chk("op7_sp", sp, 8'hFF);
    tick();

    // POP at sp=0xFF boundary
    issue(3'b100, 8'h00, 8'h5A);
    tick(); tick();
    issue(3'b010, 8'h00, 8'h00);
`ifdef STACK_GUARD_EN
    chk("uflow_no_rd", {7'd0, mem_read}, 8'd0);
    tick();
    chk("uflow_rv", {7'd0, rsp_valid}, 8'd1);
    chk("uflow_err", {7'd0, rsp_err}, 8'd1);
    chk("uflow_data", rsp_data, 8'h00);
    chk("uflow_sp", sp, 8'hFF);
    tick();
`else
    chk("wrap_rd", {7'd0, mem_read}, 8'd1);
    chk("wrap_addr", mem_addr, 8'h00);
    tick();
    chk("wrap_rv", {7'd0, rsp_valid}, 8'd1);
    chk("wrap_data", rsp_data, 8'h5A);
    chk("wrap_err", {7'd0, rsp_err}, 8'd0);
    chk("wrap_sp", sp, 8'h00);
    tick();
    issue(3'b001, 8'h00, 8'h11);
    chk("wrap_push_addr", mem_addr, 8'h00);
    tick();
    chk("wrap_push_sp", sp, 8'hFF);
    tick();
`endif

    // reset during INT_PUSH aborts the interrupt
    issue(3'b101, 8'h00, 8'h44);
    chk("abort_int_wr", {7'd0, mem_write}, 8'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_mem", {6'd0, mem_read, mem_write}, 8'd0);
    chk("abort_rv", {7'd0, rsp_valid}, 8'd0);
    chk("abort_sp", sp, 8'hFF);
    rst_n = 1'b1;
    tick();
    chk("abort_rv2", {7'd0, rsp_valid}, 8'd0);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_no_vec", {7'd0, mem_read}, 8'd0);
    tick();
    chk("abort_rv3", {7'd0, rsp_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter SP_INIT, default 8'hFF: stack pointer value after reset (top of stack).
REQ-002 SHALL have parameter VEC_ADDR, default 8'h01: memory address holding the interrupt vector.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  engine can accept a command.
REQ-007 SHALL have port cmd_op  input  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 RD, 100 WR, 101 INT; others are treated as NOP.
REQ-008 SHALL have port cmd_addr  input  8  address for RD and WR.
REQ-009 SHALL have port cmd_data  input  8  write data for PUSH/WR; return PC for INT.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_data  output  8  read result for POP/RD, vector for INT, 0 otherwise.
REQ-012 SHALL have port rsp_err  output  1  stack guard fault, qualified by rsp_valid.
REQ-013 SHALL have port sp  output  8  current stack pointer.
REQ-014 SHALL have port mem_read / mem_write  output  1 each  data memory strobes.
REQ-015 SHALL have port mem_addr / mem_wdata  output  8 each  data memory address and write data.
REQ-016 SHALL have port mem_rdata  input  8  data memory read data, combinational, valid in the same cycle mem_read is high.

Function
REQ-017 SHALL implement FSM states IDLE, PUSH, POP, RD, WR, INT_PUSH, INT_VEC, RSP.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a cycle T where cmd_valid and cmd_ready are both high.
REQ-019 SHALL, on a NOP accepted at T, go to RSP and pulse rsp_valid at T+1 with rsp_data=0, rsp_err=0, and make no memory access.
REQ-020 SHALL, for PUSH at T: at T+1 drive mem_write=1, mem_addr=sp, mem_wdata=cmd_data; sp<=sp-1; rsp_valid at T+2.
REQ-021 SHALL, for POP at T: at T+1 drive mem_read=1, mem_addr=sp+1 (8-bit); register mem_rdata into rsp_data; sp<=sp+1; rsp_valid at T+2.
REQ-022 SHALL, for RD and WR at T: access cmd_addr at T+1 (read with capture, or write of cmd_data); sp unchanged; rsp_valid at T+2.
REQ-023 SHALL, for INT at T: at T+1 push cmd_data as in PUSH; at T+2 drive mem_read=1, mem_addr=VEC_ADDR and capture the vector; rsp_valid at T+3.
REQ-024 SHALL latch cmd_op, cmd_addr and cmd_data at acceptance; input changes after T have no effect.
REQ-025 SHALL never assert mem_read and mem_write in the same cycle; both SHALL be 0 in IDLE and RSP, with mem_addr and mem_wdata at 0.
REQ-026 SHALL hold rsp_valid high for exactly one cycle (RSP), hold rsp_data until the next response, and return to IDLE after RSP.
REQ-027 SHALL make the earliest next acceptance one cycle after rsp_valid (IDLE).

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set state=IDLE, sp=SP_INIT, rsp_valid=0, rsp_data=0, rsp_err=0, all mem outputs=0, cmd_ready=1 after release.
REQ-029 SHALL, on reset mid-operation, abort the operation: no memory strobe in the cycle after the reset edge and no rsp_valid for the aborted command.

Configuration
REQ-030 SHALL, when macro STACK_GUARD_EN is defined, fault a PUSH or INT with sp==8'h00 and a POP with sp==8'hFF: no memory access, sp unchanged, rsp_valid at T+2 with rsp_err=1 and rsp_data=0.
REQ-031 SHALL, when STACK_GUARD_EN is undefined, wrap sp modulo 256 (0x00-1=0xFF, 0xFF+1=0x00) and tie rsp_err to 0.

Verification
REQ-032 SHALL cover: reset -> sp=0xFF, cmd_ready=1, all mem strobes 0.
REQ-033 SHALL cover: PUSH 0x42 -> write to M[0xFF]; sp=0xFE; POP -> read of 0xFF; rsp_data=0x42 at T+2; sp=0xFF.
REQ-034 SHALL cover: WR addr 0x10 data 0xAA, then RD 0x10 -> rsp_data=0xAA; sp unchanged at 0xFF.
REQ-035 SHALL cover: M[0x01]=0x80, INT with cmd_data 0x37 -> M[0xFF]=0x37, sp=0xFE, rsp_data=0x80 at T+3.
REQ-036 SHALL cover: POP at sp=0xFF -> with STACK_GUARD_EN: rsp_err=1, no mem_read; without it: read of M[0x00], sp=0x00.
REQ-037 SHALL cover: rst_n low during the INT_PUSH cycle -> no INT_VEC read, no rsp_valid, sp=0xFF.
